// File: rtl/midi_msg_parser.sv
// MIDI channel voice message parser: sequences receiver bytes into note,
// controller and pitch-bend events with running status and channel filtering.
module midi_msg_parser #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter logic       OMNI    = 1'b0
) (
    input  logic        i_clk_aud,
    input  logic        i_aud_rst_n,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_note_on,
    output logic        o_note_off,
    output logic [6:0]  o_note,
    output logic [6:0]  o_velocity,
    output logic        o_cc_valid,
    output logic [6:0]  o_cc_num,
    output logic [6:0]  o_cc_val,
    output logic        o_pb_valid,
    output logic [13:0] o_pitch_bend,
    output logic        o_in_sysex
);

    typedef enum logic [1:0] {
        NO_STATUS = 2'd0,
        WAIT_D1   = 2'd1,
        WAIT_D2   = 2'd2,
        SYSEX     = 2'd3
    } state_t;

    // Message type codes as held in status[6:4]
    localparam logic [2:0] T_NOTE_OFF = 3'h0;
    localparam logic [2:0] T_NOTE_ON  = 3'h1;
    localparam logic [2:0] T_CC       = 3'h3;
    localparam logic [2:0] T_PROG     = 3'h4;
    localparam logic [2:0] T_CHPRESS  = 3'h5;
    localparam logic [2:0] T_PBEND    = 3'h6;

    state_t      state_q, state_d;
    logic [2:0]  type_q, type_d;
    logic [3:0]  chan_q, chan_d;
    logic [6:0]  d1_q, d1_d;
    logic        note_on_q, note_on_d;
    logic        note_off_q, note_off_d;
    logic [6:0]  note_q, note_d;
    logic [6:0]  vel_q, vel_d;
    logic        cc_valid_q, cc_valid_d;
    logic [6:0]  cc_num_q, cc_num_d;
    logic [6:0]  cc_val_q, cc_val_d;
    logic        pb_valid_q, pb_valid_d;
    logic [13:0] pb_q, pb_d;

    logic        is_data, is_chan_status, is_realtime;
    logic        complete;
    logic [6:0]  c1, c2;

    // Byte classification
    always_comb begin
        is_data        = ~i_byte[7];
        is_realtime    = (i_byte[7:3] == 5'b11111);
        is_chan_status = i_byte[7] && (i_byte[7:4] != 4'hF);
    end

    // Next-state, data sequencing and event decode
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        chan_d     = chan_q;
        d1_d       = d1_q;
        note_on_d  = 1'b0;
        note_off_d = 1'b0;
        cc_valid_d = 1'b0;
        pb_valid_d = 1'b0;
        note_d     = note_q;
        vel_d      = vel_q;
        cc_num_d   = cc_num_q;
        cc_val_d   = cc_val_q;
        pb_d       = pb_q;
        complete   = 1'b0;
        c1         = '0;
        c2         = '0;

        if (i_byte_valid && !is_realtime) begin
            if (is_chan_status) begin
                type_d  = i_byte[6:4];
                chan_d  = i_byte[3:0];
                state_d = WAIT_D1;
            end else if (!is_data) begin
                // System common: F0 opens SysEx, everything else ends any block
                type_d  = '0;
                chan_d  = '0;
                state_d = (i_byte == 8'hF0) ? SYSEX : NO_STATUS;
            end else begin
                unique case (state_q)
                    WAIT_D1: begin
                        if (type_q == T_PROG || type_q == T_CHPRESS) begin
                            complete = 1'b1;
                            c1       = i_byte[6:0];
                        end else begin
                            d1_d    = i_byte[6:0];
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        complete = 1'b1;
                        c1       = d1_q;
                        c2       = i_byte[6:0];
                        state_d  = WAIT_D1;
                    end
                    default: ;
                endcase
            end
        end

        if (complete && (OMNI || chan_q == CHANNEL)) begin
            case (type_q)
                T_NOTE_ON, T_NOTE_OFF: begin
                    note_on_d  = (type_q == T_NOTE_ON) && (c2 != 7'd0);
                    note_off_d = !((type_q == T_NOTE_ON) && (c2 != 7'd0));
                    note_d     = c1;
                    vel_d      = c2;
                end
                T_CC: begin
                    cc_valid_d = 1'b1;
                    cc_num_d   = c1;
                    cc_val_d   = c2;
                end
                T_PBEND: begin
                    pb_valid_d = 1'b1;
                    pb_d       = {c2, c1};
                end
                default: ;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
        if (!i_aud_rst_n) begin
            state_q    <= NO_STATUS;
            type_q     <= '0;
            chan_q     <= '0;
            d1_q       <= '0;
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
            note_q     <= '0;
            vel_q      <= '0;
            cc_valid_q <= 1'b0;
            cc_num_q   <= '0;
            cc_val_q   <= '0;
            pb_valid_q <= 1'b0;
            pb_q       <= '0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            chan_q     <= chan_d;
            d1_q       <= d1_d;
            note_on_q  <= note_on_d;
            note_off_q <= note_off_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            cc_valid_q <= cc_valid_d;
            cc_num_q   <= cc_num_d;
            cc_val_q   <= cc_val_d;
            pb_valid_q <= pb_valid_d;
            pb_q       <= pb_d;
        end
    end

    assign o_note_on    = note_on_q;
    assign o_note_off   = note_off_q;
    assign o_note       = note_q;
    assign o_velocity   = vel_q;
    assign o_cc_valid   = cc_valid_q;
    assign o_cc_num     = cc_num_q;
    assign o_cc_val     = cc_val_q;
    assign o_pb_valid   = pb_valid_q;
    assign o_pitch_bend = pb_q;
    assign o_in_sysex   = (state_q == SYSEX);

endmodule
